sram_sp_2048_x_4b8_port_arbiter: RTL and testbench

//  Shares one single-port 2048 x 32-bit byte-write SRAM between two requesters, A and B.
//  - The SRAM registers its address and read strobe.
//  - The arbiter grants at most one access per cycle, round-robin on contention.
//  - It supports short locked sequences, so one port can do an uninterrupted read-modify-write.
//  - It returns registered read data to whichever port issued the read.
//  - Sits between the SRAM macro and its masters: the GIP data port and the DMA/host port.
//

---
 rtl/sram_sp_2048_x_4b8_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sram_sp_2048_x_4b8_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_sp_2048_x_4b8_port_arbiter.sv
// Two-port round-robin arbiter with bounded lock in front of one single-port byte-write SRAM.
// Latency: grant/ack combinational in the request cycle; read data returns registered two cycles after ack.
// Backpressure: a requester holds its fields until ack; the loser of a cycle simply waits, nothing is dropped.
module sram_sp_2048_x_4b8_port_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 4
) (
    input  logic                    sram_clock,
    input  logic                    sram_reset_n,
    input  logic                    req_a,
    input  logic                    req_b,
    input  logic                    lock_a,
    input  logic                    lock_b,
    input  logic                    read_not_write_a,
    input  logic                    read_not_write_b,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_a,
    input  logic [DATA_WIDTH/8-1:0] byte_enable_b,
    input  logic [ADDR_WIDTH-1:0]   address_a,
    input  logic [ADDR_WIDTH-1:0]   address_b,
    input  logic [DATA_WIDTH-1:0]   write_data_a,
    input  logic [DATA_WIDTH-1:0]   write_data_b,
    output logic                    ack_a,
    output logic                    ack_b,
    output logic                    rd_valid_a,
    output logic                    rd_valid_b,
    output logic [DATA_WIDTH-1:0]   rd_data_a,
    output logic [DATA_WIDTH-1:0]   rd_data_b,
    output logic                    sram_read_not_write,
    output logic [DATA_WIDTH/8-1:0] sram_write_enable,
    output logic [ADDR_WIDTH-1:0]   sram_address,
    output logic [DATA_WIDTH-1:0]   sram_write_data,
    input  logic [DATA_WIDTH-1:0]   sram_read_data
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_MAX_C = CNT_WIDTH'(LOCK_MAX);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic                  lock;
        logic                  read_not_write;
        logic [BE_WIDTH-1:0]   byte_enable;
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] write_data;
    } access_t;

    access_t access_a;
    access_t access_b;
    access_t access_sel;

    port_e                last_grant_q, last_grant_n;
    port_e                lock_owner_q, lock_owner_n;
    logic                 lock_vld_q, lock_vld_n;
    logic [CNT_WIDTH-1:0] lock_count_q, lock_count_n;
    logic [CNT_WIDTH-1:0] lock_count_inc;
    port_e                grant_port;
    logic                 grant_vld;
    logic                 owner_req;
    logic                 rd_pending_q;
    port_e                rd_port_q;

    assign access_a = '{lock: lock_a, read_not_write: read_not_write_a, byte_enable: byte_enable_a,
                        address: address_a, write_data: write_data_a};
    assign access_b = '{lock: lock_b, read_not_write: read_not_write_b, byte_enable: byte_enable_b,
                        address: address_b, write_data: write_data_b};

    always_comb begin
        grant_vld  = req_a | req_b;
        grant_port = PORT_A;
        owner_req  = (lock_owner_q == PORT_A) ? req_a : req_b;
        if (lock_vld_q && owner_req) begin
            grant_port = lock_owner_q;
        end else if (req_a && req_b) begin
            grant_port = (last_grant_q == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant_port = PORT_B;
        end
        access_sel = (grant_port == PORT_B) ? access_b : access_a;
    end

    assign ack_a = grant_vld && (grant_port == PORT_A);
    assign ack_b = grant_vld && (grant_port == PORT_B);

    // Lock bookkeeping: a lock that hits LOCK_MAX is released, so the other port wins the next tie.
    always_comb begin
        last_grant_n   = last_grant_q;
        lock_owner_n   = lock_owner_q;
        lock_vld_n     = lock_vld_q;
        lock_count_n   = lock_count_q;
        lock_count_inc = (lock_vld_q && lock_owner_q == grant_port) ? lock_count_q + 1'b1 : CNT_WIDTH'(1);
        if (lock_vld_q && !owner_req) begin
            lock_vld_n   = 1'b0;
            lock_count_n = '0;
        end
        if (grant_vld) begin
            last_grant_n = grant_port;
            if (access_sel.lock) begin
                if (lock_count_inc >= LOCK_MAX_C) begin
                    lock_vld_n   = 1'b0;
                    lock_count_n = LOCK_MAX_C;
                end else begin
                    lock_vld_n   = 1'b1;
                    lock_owner_n = grant_port;
                    lock_count_n = lock_count_inc;
                end
            end else begin
                lock_vld_n   = 1'b0;
                lock_count_n = '0;
            end
        end
    end

    always_ff @(posedge sram_clock or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            last_grant_q <= PORT_B;
            lock_owner_q <= PORT_A;
            lock_vld_q   <= 1'b0;
            lock_count_q <= '0;
        end else begin
            last_grant_q <= last_grant_n;
            lock_owner_q <= lock_owner_n;
            lock_vld_q   <= lock_vld_n;
            lock_count_q <= lock_count_n;
        end
    end

    always_comb begin
        sram_read_not_write = 1'b1;
        sram_write_enable   = '0;
        sram_address        = '0;
        sram_write_data     = '0;
        if (grant_vld) begin
            sram_read_not_write = access_sel.read_not_write;
            sram_address        = access_sel.address;
            if (!access_sel.read_not_write) begin
                sram_write_enable = access_sel.byte_enable;
                sram_write_data   = access_sel.write_data;
            end
        end
    end

    // Stage 1 tracks which port owns the SRAM output next cycle; stage 2 registers it to that port.
    always_ff @(posedge sram_clock or negedge sram_reset_n) begin
        if (!sram_reset_n) begin
            rd_pending_q <= 1'b0;
            rd_port_q    <= PORT_A;
            rd_valid_a   <= 1'b0;
            rd_valid_b   <= 1'b0;
            rd_data_a    <= '0;
            rd_data_b    <= '0;
        end else begin
            rd_pending_q <= grant_vld && access_sel.read_not_write;
            rd_port_q    <= grant_port;
            rd_valid_a   <= rd_pending_q && (rd_port_q == PORT_A);
            rd_valid_b   <= rd_pending_q && (rd_port_q == PORT_B);
            rd_data_a    <= (rd_pending_q && rd_port_q == PORT_A) ? sram_read_data : '0;
            rd_data_b    <= (rd_pending_q && rd_port_q == PORT_B) ? sram_read_data : '0;
        end
    end

endmodule

// File: tb/tb_sram_sp_2048_x_4b8_port_arbiter.sv
// Directed bench: arbiter plus a behavioural SRAM that registers address and read strobe.
module tb_sram_sp_2048_x_4b8_port_arbiter;

    logic        sram_clock = 1'b0;
    logic        sram_reset_n;
    logic        req_a, req_b, lock_a, lock_b;
    logic        read_not_write_a, read_not_write_b;
    logic [3:0]  byte_enable_a, byte_enable_b;
    logic [10:0] address_a, address_b;
    logic [31:0] write_data_a, write_data_b;
    logic        ack_a, ack_b, rd_valid_a, rd_valid_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        sram_read_not_write;
    logic [3:0]  sram_write_enable;
    logic [10:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;

    logic [31:0] mem [0:2047];
    logic        preload;
    int          checks = 0;
    int          failures = 0;

    always #5 sram_clock = ~sram_clock;

    sram_sp_2048_x_4b8_port_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32), .LOCK_MAX(4)) dut (
        .sram_clock(sram_clock), .sram_reset_n(sram_reset_n),
        .req_a(req_a), .req_b(req_b), .lock_a(lock_a), .lock_b(lock_b),
        .read_not_write_a(read_not_write_a), .read_not_write_b(read_not_write_b),
        .byte_enable_a(byte_enable_a), .byte_enable_b(byte_enable_b),
        .address_a(address_a), .address_b(address_b),
        .write_data_a(write_data_a), .write_data_b(write_data_b),
        .ack_a(ack_a), .ack_b(ack_b), .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .sram_read_not_write(sram_read_not_write), .sram_write_enable(sram_write_enable),
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data)
    );

    // Behavioural SRAM; preload fills word i with 0xA5000000 | i.
    always @(posedge sram_clock) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (!sram_read_not_write) begin
            for (int b = 0; b < 4; b++)
                if (sram_write_enable[b]) mem[sram_address][b*8 +: 8] <= sram_write_data[b*8 +: 8];
        end else begin
            sram_read_data <= mem[sram_address];
        end
    end

    task automatic drive_a(input logic r, input logic l, input logic rnw, input logic [3:0] be,
                           input logic [10:0] ad, input logic [31:0] wd);
        req_a = r; lock_a = l; read_not_write_a = rnw; byte_enable_a = be; address_a = ad; write_data_a = wd;
    endtask

    task automatic drive_b(input logic r, input logic l, input logic rnw, input logic [3:0] be,
                           input logic [10:0] ad, input logic [31:0] wd);
        req_b = r; lock_b = l; read_not_write_b = rnw; byte_enable_b = be; address_b = ad; write_data_b = wd;
    endtask

    task automatic idle();
        drive_a(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
        drive_b(1'b0, 1'b0, 1'b1, 4'h0, 11'h0, 32'h0);
    endtask

    task automatic test_reset();
        @(negedge sram_clock); idle(); #1;
        checks++;
        if ({ack_a, ack_b, rd_valid_a, rd_valid_b} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {ack_a, ack_b, rd_valid_a, rd_valid_b});
        end
        checks++;
        if ({rd_data_a, rd_data_b} !== 64'h0) begin
            failures++; $display("FAIL reset_rd_data got=%h exp=0", {rd_data_a, rd_data_b});
        end
        checks++;
        if ({sram_read_not_write, sram_write_enable} !== 5'b10000) begin
            failures++; $display("FAIL reset_sram_ctl got=%b exp=10000", {sram_read_not_write, sram_write_enable});
        end
    endtask

    task automatic test_write_read();
        @(negedge sram_clock); idle(); drive_a(1'b1, 1'b0, 1'b0, 4'hF, 11'h005, 32'hDEADBEEF); #1;
        checks++;
        if ({ack_a, ack_b} !== 2'b10) begin failures++; $display("FAIL wr_ack got=%b exp=10", {ack_a, ack_b}); end
        checks++;
        if ({sram_read_not_write, sram_write_enable, sram_address, sram_write_data} !== {1'b0, 4'hF, 11'h005, 32'hDEADBEEF}) begin
            failures++; $display("FAIL wr_drive got=%b/%h/%h/%h exp=0/f/005/deadbeef",
                                 sram_read_not_write, sram_write_enable, sram_address, sram_write_data);
        end
        @(negedge sram_clock); idle(); drive_b(1'b1, 1'b0, 1'b1, 4'h0, 11'h005, 32'h0); #1;
        checks++;
        if ({ack_a, ack_b} !== 2'b01) begin failures++; $display("FAIL rd_ack got=%b exp=01", {ack_a, ack_b}); end
        checks++;
        if ({sram_read_not_write, sram_write_enable, sram_address} !== {1'b1, 4'h0, 11'h005}) begin
            failures++; $display("FAIL rd_drive got=%b/%h/%h exp=1/0/005", sram_read_not_write, sram_write_enable, sram_address);
        end
        @(negedge sram_clock); idle(); #1;
        checks++;
        if (rd_valid_b !== 1'b0) begin failures++; $display("FAIL rd_early got=%b exp=0", rd_valid_b); end
        @(negedge sram_clock); #1;
        checks++;
        if ({rd_valid_a, rd_valid_b, rd_data_b} !== {2'b01, 32'hDEADBEEF}) begin
            failures++; $display("FAIL rd_return got=%b%b/%h exp=01/deadbeef", rd_valid_a, rd_valid_b, rd_data_b);
        end
    endtask

    task automatic test_alternating();
        logic        exp_a, exp_b, exp_va, exp_vb;
        logic [31:0] exp_dat;
        for (int c = 0; c < 8; c++) begin
            @(negedge sram_clock);
            if (c < 6) begin
                drive_a(1'b1, 1'b0, 1'b1, 4'h0, (c == 0) ? 11'h010 : 11'(16 + 2 * ((c + 1) / 2)), 32'h0);
                drive_b(1'b1, 1'b0, 1'b1, 4'h0, 11'(17 + 2 * (c / 2)), 32'h0);
            end else begin
                idle();
            end
            #1;
            exp_a   = (c < 6) && (c % 2 == 0);
            exp_b   = (c < 6) && (c % 2 == 1);
            exp_va  = (c == 2) || (c == 4) || (c == 6);
            exp_vb  = (c == 3) || (c == 5) || (c == 7);
            exp_dat = 32'hA500_0000 | 32'(14 + c);
            checks++;
            if ({ack_a, ack_b} !== {exp_a, exp_b}) begin
                failures++; $display("FAIL alt_ack c=%0d got=%b exp=%b", c, {ack_a, ack_b}, {exp_a, exp_b});
            end
            checks++;
            if ({rd_valid_a, rd_valid_b} !== {exp_va, exp_vb}) begin
                failures++; $display("FAIL alt_valid c=%0d got=%b exp=%b", c, {rd_valid_a, rd_valid_b}, {exp_va, exp_vb});
            end
            checks++;
            if ({rd_data_a, rd_data_b} !== {exp_va ? exp_dat : 32'h0, exp_vb ? exp_dat : 32'h0}) begin
                failures++; $display("FAIL alt_data c=%0d got=%h/%h exp=%h valid=%b%b", c, rd_data_a, rd_data_b,
                                     exp_dat, exp_va, exp_vb);
            end
        end
    endtask

    task automatic test_byte_enable();
        @(negedge sram_clock); idle(); drive_a(1'b1, 1'b0, 1'b0, 4'hF, 11'h020, 32'h11223344);
        @(negedge sram_clock); drive_a(1'b1, 1'b0, 1'b0, 4'h2, 11'h020, 32'h0000AB00);
        @(negedge sram_clock); drive_a(1'b1, 1'b0, 1'b1, 4'h0, 11'h020, 32'h0); #1;
        checks++;
        if (ack_a !== 1'b1) begin failures++; $display("FAIL be_rd_ack got=%b exp=1", ack_a); end
        @(negedge sram_clock); drive_a(1'b1, 1'b0, 1'b0, 4'h0, 11'h020, 32'hFFFFFFFF); #1;
        checks++;
        if ({ack_a, sram_read_not_write, sram_write_enable} !== 6'b100000) begin
            failures++; $display("FAIL be0_ack got=%b exp=100000", {ack_a, sram_read_not_write, sram_write_enable});
        end
        @(negedge sram_clock); drive_a(1'b1, 1'b0, 1'b1, 4'h0, 11'h020, 32'h0); #1;
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 32'h1122AB44}) begin
            failures++; $display("FAIL be_merge got=%b/%h exp=1/1122ab44", rd_valid_a, rd_data_a);
        end
        @(negedge sram_clock); idle(); #1;
        checks++;
        if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL be_gap got=%b exp=0", rd_valid_a); end
        @(negedge sram_clock); #1;
        checks++;
        if ({rd_valid_a, rd_data_a} !== {1'b1, 32'h1122AB44}) begin
            failures++; $display("FAIL be0_unchanged got=%b/%h exp=1/1122ab44", rd_valid_a, rd_data_a);
        end
    endtask

    task automatic test_lock_max();
        logic exp_b;
        for (int c = 0; c < 7; c++) begin
            @(negedge sram_clock);
            drive_a(1'b1, 1'b1, 1'b1, 4'h0, 11'h030, 32'h0);
            drive_b(1'b1, 1'b0, 1'b1, 4'h0, 11'h031, 32'h0);
            #1;
            exp_b = (c == 0) || (c == 5);
            checks++;
            if ({ack_a, ack_b} !== {~exp_b, exp_b}) begin
                failures++; $display("FAIL lock_max c=%0d got=%b exp=%b", c, {ack_a, ack_b}, {~exp_b, exp_b});
            end
        end
        repeat (3) begin @(negedge sram_clock); idle(); end
    endtask

    task automatic test_lock_release();
        logic exp_b;
        for (int c = 0; c < 4; c++) begin
            @(negedge sram_clock);
            drive_a(1'b1, (c < 2), 1'b1, 4'h0, 11'h040, 32'h0);
            drive_b(1'b1, 1'b0, 1'b1, 4'h0, 11'h041, 32'h0);
            #1;
            exp_b = (c == 0) || (c == 3);
            checks++;
            if ({ack_a, ack_b} !== {~exp_b, exp_b}) begin
                failures++; $display("FAIL lock_release c=%0d got=%b exp=%b", c, {ack_a, ack_b}, {~exp_b, exp_b});
            end
        end
        repeat (3) begin @(negedge sram_clock); idle(); end
    endtask

    task automatic test_reset_inflight();
        @(negedge sram_clock); idle(); drive_a(1'b1, 1'b0, 1'b1, 4'h0, 11'h010, 32'h0); #1;
        checks++;
        if (ack_a !== 1'b1) begin failures++; $display("FAIL rst_rd_ack got=%b exp=1", ack_a); end
        @(negedge sram_clock); idle(); #1;
        sram_reset_n = 1'b0; #1;
        checks++;
        if ({rd_valid_a, rd_data_a} !== 33'h0) begin
            failures++; $display("FAIL rst_clear got=%b/%h exp=0/0", rd_valid_a, rd_data_a);
        end
        #1 sram_reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge sram_clock); #1;
            checks++;
            if (rd_valid_a !== 1'b0) begin
                failures++; $display("FAIL rst_dropped c=%0d got=%b exp=0", c, rd_valid_a);
            end
        end
        @(negedge sram_clock);
        drive_a(1'b1, 1'b0, 1'b1, 4'h0, 11'h050, 32'h0);
        drive_b(1'b1, 1'b0, 1'b1, 4'h0, 11'h051, 32'h0);
        #1;
        checks++;
        if ({ack_a, ack_b} !== 2'b10) begin failures++; $display("FAIL rst_first_tie got=%b exp=10", {ack_a, ack_b}); end
        repeat (4) begin @(negedge sram_clock); idle(); end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge sram_clock); idle(); #1;
            checks++;
            if ({ack_a, ack_b, rd_valid_a, rd_valid_b, sram_read_not_write, sram_write_enable} !== 9'b000010000) begin
                failures++; $display("FAIL idle_ctl c=%0d got=%b exp=000010000", c,
                                     {ack_a, ack_b, rd_valid_a, rd_valid_b, sram_read_not_write, sram_write_enable});
            end
            checks++;
            if ({sram_address, sram_write_data} !== 43'h0) begin
                failures++; $display("FAIL idle_bus c=%0d got=%h/%h exp=0/0", c, sram_address, sram_write_data);
            end
        end
    endtask

    initial begin
        idle();
        preload      = 1'b0;
        sram_reset_n = 1'b0;
        repeat (2) @(negedge sram_clock);
        test_reset();
        @(negedge sram_clock); sram_reset_n = 1'b1; preload = 1'b1;
        @(negedge sram_clock); preload = 1'b0;
        test_write_read();
        test_alternating();
        test_byte_enable();
        test_lock_max();
        test_lock_release();
        test_reset_inflight();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
